// File: rtl/ctrl_symbol_rx_pkg.sv
// ctrl_symbol_rx_pkg: shared types and constants for the serial control-symbol receiver
package ctrl_symbol_rx_pkg;

   typedef enum logic [1:0] {
      a = 2'b00,
      b = 2'b01,
      c = 2'b10
   } ctrl_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_FRAME,
      ERR_PARITY,
      ERR_ILLEGAL
   } err_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ctrl_rx_state_t;

   localparam int FRAME_BITS = 5;

   // even parity bit that makes the XOR of data and parity zero
   function automatic logic even_parity(input logic [1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/ctrl_symbol_rx_bit_sync.sv
// ctrl_symbol_rx_bit_sync: multi-stage synchroniser for an asynchronous idle-high input
module ctrl_symbol_rx_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q, sync_d;

   // shift the raw input one stage deeper every cycle
   always_comb sync_d = {sync_q[STAGES-2:0], d_i};

   // stages preset to the idle-high level so reset never looks like a start bit
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sync_q <= '1;
      else         sync_q <= sync_d;

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ctrl_symbol_rx.sv
// ctrl_symbol_rx: deserialises 5-bit framed serial symbols into ctrl_t, flags framing/parity/illegal errors
module ctrl_symbol_rx
   import ctrl_symbol_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [1:0] control_signal_o,
   output logic       valid_o,
   output logic       err_o,
   output logic [1:0] err_code_o,
   output logic       busy_o
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] MID  = BW'(CLKS_PER_BIT/2 - 1);
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

   logic           rx_s;
   ctrl_rx_state_t state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic           bit_q, bit_d;
   logic [1:0]     data_q, data_d;
   logic           par_err_q, par_err_d;
   logic           break_q, break_d;
   logic [1:0]     ctrl_q, ctrl_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   err_t           err_code_q, err_code_d;
   logic           tick;

   ctrl_symbol_rx_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (rx_i),
      .q_o    (rx_s)
   );

   assign tick = (baud_q == LAST);

   // frame sequencing, bit capture and the end-of-frame accept/reject decision
   always_comb begin
      state_d    = state_q;
      baud_d     = tick ? '0 : baud_q + 1'b1;
      bit_d      = bit_q;
      data_d     = data_q;
      par_err_d  = par_err_q;
      break_d    = break_q;
      ctrl_d     = ctrl_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      case (state_q)
         ST_IDLE: begin
            baud_d  = '0;
            bit_d   = 1'b0;
            break_d = break_q & ~rx_s;
            if (!break_q && !rx_s) state_d = ST_START;
         end
         ST_START:
            if (baud_q == MID) begin
               baud_d  = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         ST_DATA:
            if (tick) begin
               data_d  = {rx_s, data_q[1]};
               bit_d   = 1'b1;
               state_d = bit_q ? ST_PARITY : ST_DATA;
            end
         ST_PARITY:
            if (tick) begin
               par_err_d = rx_s ^ even_parity(data_q);
               state_d   = ST_STOP;
            end
         ST_STOP:
            if (tick) begin
               state_d = ST_IDLE;
               if (!rx_s) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_FRAME;
                  break_d    = 1'b1;
               end else if (par_err_q) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_PARITY;
               end else if (&data_q) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_ILLEGAL;
               end else begin
                  valid_d = 1'b1;
                  ctrl_d  = data_q;
               end
            end
         default: state_d = ST_IDLE;
      endcase
   end

   // register all receiver state and outputs; reset drops any partial frame
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= 1'b0;
         data_q     <= '0;
         par_err_q  <= 1'b0;
         break_q    <= 1'b0;
         ctrl_q     <= a;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         par_err_q  <= par_err_d;
         break_q    <= break_d;
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end

   assign control_signal_o = ctrl_q;
   assign valid_o          = valid_q;
   assign err_o            = err_q;
   assign err_code_o       = err_code_q;
   assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ctrl_symbol_rx.sv
// tb_ctrl_symbol_rx: directed and random serial frames checked against a frame-level scoreboard
module tb_ctrl_symbol_rx;

   localparam int CPB = 4;

   typedef struct {
      logic       is_err;
      logic [1:0] code;
      logic [1:0] ctrl;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       rx_i = 1'b1;
   logic [1:0] control_signal_o;
   logic       valid_o;
   logic       err_o;
   logic [1:0] err_code_o;
   logic       busy_o;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [1:0] model_ctrl = 2'b00;
   int         checks = 0;
   int         errors = 0;
   int         extra = 0;

   ctrl_symbol_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .rx_i             (rx_i),
      .control_signal_o (control_signal_o),
      .valid_o          (valid_o),
      .err_o            (err_o),
      .err_code_o       (err_code_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // frame bits, index 0 sent first: start, d0, d1, parity, stop
   function automatic logic [4:0] mk(input logic [1:0] d, input logic bad_par, input logic bad_stop);
      return {~bad_stop, (d[0] ^ d[1]) ^ bad_par, d[1], d[0], 1'b0};
   endfunction

   // frame-level model: what the receiver must report for a whole frame
   task automatic expect_frame(input logic [4:0] f);
      exp_t e;
      logic [1:0] d;
      d = {f[2], f[1]};
      e.is_err = 1'b1;
      if (!f[4])                     e.code = 2'd1;
      else if (f[3] != (f[1] ^ f[2])) e.code = 2'd2;
      else if (d == 2'b11)            e.code = 2'd3;
      else begin
         e.is_err   = 1'b0;
         e.code     = 2'd0;
         model_ctrl = d;
      end
      e.ctrl = model_ctrl;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [4:0] f);
      for (int i = 0; i < 5; i++) begin
         rx_i = f[i];
         repeat (CPB) @(negedge clk_i);
      end
   endtask

   task automatic send_exp(input logic [4:0] f);
      expect_frame(f);
      send(f);
   endtask

   task automatic idle(input int bits);
      rx_i = 1'b1;
      repeat (bits * CPB) @(negedge clk_i);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"},  control_signal_o, 2'b00);
      check({tag, "_valid"}, valid_o, 1'b0);
      check({tag, "_err"},   err_o, 1'b0);
      check({tag, "_code"},  err_code_o, 2'd0);
      check({tag, "_busy"},  busy_o, 1'b0);
   endtask

   // scoreboard: every pulse must match the oldest outstanding frame
   always @(negedge clk_i)
      if (rst_ni && (valid_o || err_o)) begin
         check("excl", valid_o & err_o, 1'b0);
         if (exp_q.size() == 0) extra++;
         else begin
            mon_e = exp_q.pop_front();
            check("kind", err_o, mon_e.is_err);
            if (err_o) check("code", err_code_o, mon_e.code);
            check("ctrl", control_signal_o, mon_e.ctrl);
         end
      end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] d;
      logic       bp, bs;
      int         gap;
      repeat (3) @(negedge clk_i);
      #1;
      check_reset_outputs("por");
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(2);
      send_exp(mk(2'b01, 1'b0, 1'b0));
      send_exp(mk(2'b10, 1'b0, 1'b0));
      idle(2);
      check("ctrl_c", control_signal_o, 2'b10);
      send_exp(mk(2'b01, 1'b1, 1'b0));
      idle(2);
      check("ctrl_hold_par", control_signal_o, 2'b10);
      send_exp(mk(2'b00, 1'b0, 1'b1));
      rx_i = 1'b0;
      repeat (3 * CPB) @(negedge clk_i);
      idle(2);
      send_exp(mk(2'b00, 1'b0, 1'b0));
      idle(2);
      check("ctrl_a", control_signal_o, 2'b00);
      send_exp(mk(2'b01, 1'b0, 1'b0));
      send_exp(mk(2'b11, 1'b0, 1'b0));
      idle(2);
      check("ctrl_hold_ill", control_signal_o, 2'b01);
      rx_i = 1'b0;
      @(negedge clk_i);
      idle(3);
      check("busy_idle", busy_o, 1'b0);
      for (int n = 0; n < 60; n++) begin
         d   = 2'($urandom_range(0, 3));
         bp  = ($urandom_range(0, 3) == 0);
         bs  = ($urandom_range(0, 6) == 0);
         gap = $urandom_range(0, 2);
         if (bs && gap == 0) gap = 1;
         send_exp(mk(d, bp, bs));
         idle(gap);
      end
      idle(3);
      check("ctrl_rand", control_signal_o, model_ctrl);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk_i);
      repeat (CPB + 2) @(negedge clk_i);
      check("busy_mid", busy_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("mid");
      model_ctrl = 2'b00;
      rx_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(2);
      send_exp(mk(2'b01, 1'b0, 1'b0));
      idle(3);
      check("ctrl_final", control_signal_o, 2'b01);
      check("drain", exp_q.size(), 0);
      check("extra", extra, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
